// File: rtl/elevator_request_unit.sv
// ---------------------------------------------------------------------------
// elevator_request_unit
//
// Request register for the elevator controller. It captures hall up/down calls
// and cabin floor-button presses. It holds each request until the controller
// reports a stop at that floor, and it gives the direction-scheduling FSM
// summary flags relative to the cabin position.
//
// Ports:
//   i_clk            system clock, all state changes on the rising edge
//   i_rst_n          synchronous active-low reset
//   i_up_button      raw hall up-call buttons (asynchronous, level)
//   i_down_button    raw hall down-call buttons (asynchronous, level)
//   i_floor_button   raw cabin floor buttons (asynchronous, level)
//   i_current_floor  floor the cabin is at or passing
//   i_service_valid  one-cycle pulse: cabin stopped, doors opening
//   i_service_floor  floor being served, qualified by i_service_valid
//   i_service_dir    departure direction of the stop (1 = up, 0 = down)
//   o_up_request     pending hall up calls (registered)
//   o_down_request   pending hall down calls (registered)
//   o_floor_request  pending cabin requests (registered)
//   o_any_request    any request pending anywhere
//   o_req_above      a request exists above i_current_floor
//   o_req_below      a request exists below i_current_floor
//   o_req_here       a request exists at i_current_floor
// ---------------------------------------------------------------------------
module elevator_request_unit #(
    parameter int MAX_FLOOR = 8,
    parameter int FLOOR_W   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [MAX_FLOOR-1:0] i_up_button,
    input  logic [MAX_FLOOR-1:0] i_down_button,
    input  logic [MAX_FLOOR-1:0] i_floor_button,
    input  logic [FLOOR_W-1:0]   i_current_floor,
    input  logic                 i_service_valid,
    input  logic [FLOOR_W-1:0]   i_service_floor,
    input  logic                 i_service_dir,
    output logic [MAX_FLOOR-1:0] o_up_request,
    output logic [MAX_FLOOR-1:0] o_down_request,
    output logic [MAX_FLOOR-1:0] o_floor_request,
    output logic                 o_any_request,
    output logic                 o_req_above,
    output logic                 o_req_below,
    output logic                 o_req_here
);

    // The top floor has no up call and the ground floor has no down call.
    localparam logic [MAX_FLOOR-1:0] UP_ALLOWED   = {1'b0, {(MAX_FLOOR-1){1'b1}}};
    localparam logic [MAX_FLOOR-1:0] DOWN_ALLOWED = {{(MAX_FLOOR-1){1'b1}}, 1'b0};

    logic [MAX_FLOOR-1:0] r_upSync1;
    logic [MAX_FLOOR-1:0] r_upSync2;
    logic [MAX_FLOOR-1:0] r_upHist;
    logic [MAX_FLOOR-1:0] r_downSync1;
    logic [MAX_FLOOR-1:0] r_downSync2;
    logic [MAX_FLOOR-1:0] r_downHist;
    logic [MAX_FLOOR-1:0] r_floorSync1;
    logic [MAX_FLOOR-1:0] r_floorSync2;
    logic [MAX_FLOOR-1:0] r_floorHist;

    logic [MAX_FLOOR-1:0] r_upRequest;
    logic [MAX_FLOOR-1:0] r_downRequest;
    logic [MAX_FLOOR-1:0] r_floorRequest;

    logic [MAX_FLOOR-1:0] w_upPress;
    logic [MAX_FLOOR-1:0] w_downPress;
    logic [MAX_FLOOR-1:0] w_floorPress;
    logic [MAX_FLOOR-1:0] w_serviceHit;
    logic [MAX_FLOOR-1:0] w_upClear;
    logic [MAX_FLOOR-1:0] w_downClear;
    logic [MAX_FLOOR-1:0] w_pending;
    int                   w_curIdx;

    // Two-flop synchroniser plus a history flop for every button. The history
    // flop lets us see a rising edge, so a held button counts as one press.
    // Clearing all three flops in reset makes a button that is held through
    // reset release look like a fresh press.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_upSync1    <= '0;
            r_upSync2    <= '0;
            r_upHist     <= '0;
            r_downSync1  <= '0;
            r_downSync2  <= '0;
            r_downHist   <= '0;
            r_floorSync1 <= '0;
            r_floorSync2 <= '0;
            r_floorHist  <= '0;
        end else begin
            r_upSync1    <= i_up_button;
            r_upSync2    <= r_upSync1;
            r_upHist     <= r_upSync2;
            r_downSync1  <= i_down_button;
            r_downSync2  <= r_downSync1;
            r_downHist   <= r_downSync2;
            r_floorSync1 <= i_floor_button;
            r_floorSync2 <= r_floorSync1;
            r_floorHist  <= r_floorSync2;
        end
    end

    assign w_upPress    = r_upSync2 & ~r_upHist;
    assign w_downPress  = r_downSync2 & ~r_downHist;
    assign w_floorPress = r_floorSync2 & ~r_floorHist;

    // Decode the service pulse into a one-hot floor mask. A service floor
    // beyond the last real floor matches no bit, so it changes nothing.
    always_comb begin
        w_serviceHit = '0;
        for (int i = 0; i < MAX_FLOOR; i++) begin
            if (i_service_valid && (i_service_floor == FLOOR_W'(i))) begin
                w_serviceHit[i] = 1'b1;
            end
        end
    end

    assign w_upClear   = w_serviceHit & {MAX_FLOOR{i_service_dir}};
    assign w_downClear = w_serviceHit & {MAX_FLOOR{~i_service_dir}};

    // Request flops. The clear mask is applied last, so when a press and a
    // service hit the same bit in the same cycle, the service wins and the
    // press is dropped. A cabin press toggles its bit, so pressing again cancels.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_upRequest    <= '0;
            r_downRequest  <= '0;
            r_floorRequest <= '0;
        end else begin
            r_upRequest    <= (r_upRequest | (w_upPress & UP_ALLOWED)) & ~w_upClear;
            r_downRequest  <= (r_downRequest | (w_downPress & DOWN_ALLOWED)) & ~w_downClear;
            r_floorRequest <= (r_floorRequest ^ w_floorPress) & ~w_serviceHit;
        end
    end

    assign o_up_request    = r_upRequest;
    assign o_down_request  = r_downRequest;
    assign o_floor_request = r_floorRequest;

    assign w_pending     = r_upRequest | r_downRequest | r_floorRequest;
    assign o_any_request = |w_pending;
    assign w_curIdx      = int'(i_current_floor);

    // Position-relative summary flags for the scheduler. When the cabin
    // position is outside the building, all position flags are held low.
    always_comb begin
        o_req_above = 1'b0;
        o_req_below = 1'b0;
        o_req_here  = 1'b0;
        if (w_curIdx < MAX_FLOOR) begin
            for (int i = 0; i < MAX_FLOOR; i++) begin
                if (w_pending[i]) begin
                    if (i > w_curIdx) begin
                        o_req_above = 1'b1;
                    end else if (i < w_curIdx) begin
                        o_req_below = 1'b1;
                    end else begin
                        o_req_here = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_elevator_request_unit.sv
// ---------------------------------------------------------------------------
// tb_elevator_request_unit
//
// Testbench for elevator_request_unit. It drives an 8-floor instance and a
// 6-floor instance from the same stimulus. The low six button bits go to the
// 6-floor unit. A reference model updates at every rising edge and queues the
// expected register contents. A monitor on the falling edge pops each entry
// and compares it against both units. The expected flags are derived from the
// queued request state and the current floor.
// ---------------------------------------------------------------------------
module tb_elevator_request_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] upB;
    logic [7:0] downB;
    logic [7:0] floorB;
    logic [2:0] curFloor;
    logic       svcValid;
    logic [2:0] svcFloor;
    logic       svcDir;

    logic [7:0] upReq8;
    logic [7:0] downReq8;
    logic [7:0] floorReq8;
    logic       any8;
    logic       above8;
    logic       below8;
    logic       here8;
    logic [5:0] upReq6;
    logic [5:0] downReq6;
    logic [5:0] floorReq6;
    logic       any6;
    logic       above6;
    logic       below6;
    logic       here6;

    typedef struct {
        logic [7:0] up8;
        logic [7:0] down8;
        logic [7:0] floor8;
        logic [5:0] up6;
        logic [5:0] down6;
        logic [5:0] floor6;
        int         phase;
    } exp_t;

    exp_t       expQ[$];
    exp_t       modE;
    exp_t       monE;
    logic [7:0] mUp[2];
    logic [7:0] mDown[2];
    logic [7:0] mFloor[2];
    logic [7:0] hUp[$];
    logic [7:0] hDown[$];
    logic [7:0] hFloor[$];
    int         phaseId = 0;
    int         checks  = 0;
    int         errors  = 0;

    always #5 clk = ~clk;

    elevator_request_unit #(.MAX_FLOOR(8), .FLOOR_W(3)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_up_button(upB), .i_down_button(downB), .i_floor_button(floorB),
        .i_current_floor(curFloor), .i_service_valid(svcValid),
        .i_service_floor(svcFloor), .i_service_dir(svcDir),
        .o_up_request(upReq8), .o_down_request(downReq8), .o_floor_request(floorReq8),
        .o_any_request(any8), .o_req_above(above8), .o_req_below(below8), .o_req_here(here8)
    );

    elevator_request_unit #(.MAX_FLOOR(6), .FLOOR_W(3)) dut6 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_up_button(upB[5:0]), .i_down_button(downB[5:0]), .i_floor_button(floorB[5:0]),
        .i_current_floor(curFloor), .i_service_valid(svcValid),
        .i_service_floor(svcFloor), .i_service_dir(svcDir),
        .o_up_request(upReq6), .o_down_request(downReq6), .o_floor_request(floorReq6),
        .o_any_request(any6), .o_req_above(above6), .o_req_below(below6), .o_req_here(here6)
    );

    // Apply one request-rule step for a building of n floors, given the
    // presses that mature at this edge.
    task automatic modelFloors(input int d, input int n,
                               input logic [7:0] pu, input logic [7:0] pd, input logic [7:0] pf);
        for (int i = 0; i < n; i++) begin
            bit served;
            served = svcValid && (int'(svcFloor) == i);
            if (served && svcDir) mUp[d][i] = 1'b0;
            else if (pu[i] && i != n - 1) mUp[d][i] = 1'b1;
            if (served && !svcDir) mDown[d][i] = 1'b0;
            else if (pd[i] && i != 0) mDown[d][i] = 1'b1;
            if (served) mFloor[d][i] = 1'b0;
            else if (pf[i]) mFloor[d][i] = ~mFloor[d][i];
        end
    endtask

    // Reference model. The history queues hold the button levels sampled at
    // the last three edges, oldest first. A press matures when the sample
    // from two edges ago is high and the sample from three edges ago is low.
    always @(posedge clk) begin
        logic [7:0] pu;
        logic [7:0] pd;
        logic [7:0] pf;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mUp[d] = '0;
                mDown[d] = '0;
                mFloor[d] = '0;
            end
            hUp = '{8'h00, 8'h00, 8'h00};
            hDown = '{8'h00, 8'h00, 8'h00};
            hFloor = '{8'h00, 8'h00, 8'h00};
        end else begin
            pu = hUp[1] & ~hUp[0];
            pd = hDown[1] & ~hDown[0];
            pf = hFloor[1] & ~hFloor[0];
            modelFloors(0, 8, pu, pd, pf);
            modelFloors(1, 6, pu, pd, pf);
            hUp.push_back(upB);
            void'(hUp.pop_front());
            hDown.push_back(downB);
            void'(hDown.pop_front());
            hFloor.push_back(floorB);
            void'(hFloor.pop_front());
        end
        modE.up8 = mUp[0];
        modE.down8 = mDown[0];
        modE.floor8 = mFloor[0];
        modE.up6 = mUp[1][5:0];
        modE.down6 = mDown[1][5:0];
        modE.floor6 = mFloor[1][5:0];
        modE.phase = phaseId;
        expQ.push_back(modE);
    end

    // Expected flags, packed as {any, above, below, here}.
    function automatic logic [3:0] expFlags(input logic [7:0] pend, input int n, input int cf);
        logic [3:0] f;
        f = '0;
        f[3] = |pend;
        if (cf < n) begin
            for (int i = 0; i < n; i++) begin
                if (pend[i]) begin
                    if (i > cf) f[2] = 1'b1;
                    if (i < cf) f[1] = 1'b1;
                    if (i == cf) f[0] = 1'b1;
                end
            end
        end
        return f;
    endfunction

    task automatic checkOutput(input string name, input int phase,
                               input logic [7:0] actual, input logic [7:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s (phase %0d) at %0t: got %h, expected %h",
                     name, phase, $time, actual, required);
        end
    endtask

    // Monitor: every falling edge, pop the state expected after the previous
    // rising edge and compare it against both units.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            checkOutput("up_request8", monE.phase, upReq8, monE.up8);
            checkOutput("down_request8", monE.phase, downReq8, monE.down8);
            checkOutput("floor_request8", monE.phase, floorReq8, monE.floor8);
            checkOutput("flags8", monE.phase, {4'b0, any8, above8, below8, here8},
                        {4'b0, expFlags(monE.up8 | monE.down8 | monE.floor8, 8, int'(curFloor))});
            checkOutput("up_request6", monE.phase, {2'b0, upReq6}, {2'b0, monE.up6});
            checkOutput("down_request6", monE.phase, {2'b0, downReq6}, {2'b0, monE.down6});
            checkOutput("floor_request6", monE.phase, {2'b0, floorReq6}, {2'b0, monE.floor6});
            checkOutput("flags6", monE.phase, {4'b0, any6, above6, below6, here6},
                        {4'b0, expFlags({2'b0, monE.up6 | monE.down6 | monE.floor6}, 6, int'(curFloor))});
        end
    end

    // Drive one cycle of inputs and hold them through the next rising edge.
    task automatic applyStimulus(input logic r, input logic [7:0] u, input logic [7:0] dn,
                                 input logic [7:0] f, input logic [2:0] cf, input logic sv,
                                 input logic [2:0] sf, input logic dir);
        rst_n = r;
        upB = u;
        downB = dn;
        floorB = f;
        curFloor = cf;
        svcValid = sv;
        svcFloor = sf;
        svcDir = dir;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        repeat (2) applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset with every button held, then keep up[2] held after release.
        phaseId = 1;
        repeat (2) applyStimulus(1'b0, 8'hFF, 8'hFF, 8'hFF, 3'd0, 1'b0, 3'd0, 1'b0);
        repeat (6) applyStimulus(1'b1, 8'h04, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);

        // A served stop clears only the call for its departure direction.
        phaseId = 2;
        doReset();
        applyStimulus(1'b1, 8'h08, 8'h08, 8'h00, 3'd3, 1'b0, 3'd0, 1'b0);
        repeat (4) applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 3'd3, 1'b1, 3'd3, 1'b1);
        repeat (3) applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 3'd3, 1'b0, 3'd0, 1'b0);

        // A second cabin press cancels the first.
        phaseId = 3;
        doReset();
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h20, 3'd2, 1'b0, 3'd0, 1'b0);
        repeat (4) applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h20, 3'd2, 1'b0, 3'd0, 1'b0);
        repeat (4) applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 3'd2, 1'b0, 3'd0, 1'b0);

        // End floors ignore the impossible direction.
        phaseId = 4;
        doReset();
        repeat (5) applyStimulus(1'b1, 8'h80, 8'h01, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);

        // Service lands on the same edge the down press at floor 4 matures.
        phaseId = 5;
        doReset();
        repeat (2) applyStimulus(1'b1, 8'h00, 8'h10, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 8'h00, 8'h10, 8'h00, 3'd0, 1'b1, 3'd4, 1'b0);
        repeat (4) applyStimulus(1'b1, 8'h00, 8'h10, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);

        // Requests at floors 0 and 6, then sweep the cabin position.
        phaseId = 6;
        doReset();
        applyStimulus(1'b1, 8'h00, 8'h00, 8'h41, 3'd0, 1'b0, 3'd0, 1'b0);
        repeat (3) applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
        for (int cf = 0; cf < 8; cf++) begin
            applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 3'(cf), 1'b0, 3'd0, 1'b0);
        end

        // Randomised traffic with occasional resets.
        phaseId = 7;
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 63) != 0),
                          ($urandom_range(0, 2) == 0) ? 8'($urandom) : upB,
                          ($urandom_range(0, 2) == 0) ? 8'($urandom) : downB,
                          ($urandom_range(0, 2) == 0) ? 8'($urandom) : floorB,
                          3'($urandom),
                          ($urandom_range(0, 3) == 0),
                          3'($urandom),
                          1'($urandom));
        end

        repeat (2) applyStimulus(1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
